// File: rtl/ysyx_220053_ifu.sv
// rtl/ysyx_220053_ifu.sv - instruction fetch unit: single-outstanding imem fetch, PC/instr FIFO toward decode
module ysyx_220053_ifu #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000),
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_i,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            halted_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic            req_epoch;
    logic            epoch;
    logic            halted;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic redirect;
    logic push;
    logic pop;

    assign redirect = redirect_valid && (state != S_HALT);
    // Responses from before the latest redirect carry a stale epoch and are discarded.
    assign push = (state == S_WAIT) && imem_rsp_valid && (req_epoch == epoch) && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect;

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = req_addr;
    assign instr_valid    = (count != '0) && !halted;
    assign instr_o        = fifo_instr[rd_ptr];
    assign pc_o           = fifo_pc[rd_ptr];
    assign halted_o       = halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            req_addr  <= '0;
            req_epoch <= 1'b0;
            epoch     <= 1'b0;
            halted    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            if (halt_i) begin
                halted <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (halted) begin
                        state <= S_HALT;
                    end else if ((count < FULL) && !redirect) begin
                        req_addr  <= fetch_pc;
                        req_epoch <= epoch;
                        fetch_pc  <= fetch_pc + XLEN'(4);
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_HALT;
            endcase

            if (push) begin
                fifo_pc[wr_ptr]    <= req_addr;
                fifo_instr[wr_ptr] <= imem_rsp_data;
            end

            if (redirect) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                epoch    <= ~epoch;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// tb/tb_ysyx_220053_ifu.sv - randomized self-checking bench for ysyx_220053_ifu
module tb_ysyx_220053_ifu;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_i;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        halted_o;

    ysyx_220053_ifu #(.XLEN(64), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_i(halt_i),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_o(instr_o), .pc_o(pc_o),
        .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RESET_PC) return 32'h0010_0093;
        if (a == RESET_PC + 64'd4) return 32'h0020_0113;
        return a[31:0] ^ 32'h5a5a_0013;
    endfunction

    // Reference model: delivered PCs form a +4 sequence restarting at each redirect target;
    // accepted request addresses do likewise, except a request already on the bus at a redirect.
    logic [63:0] exp_pc;
    logic [63:0] req_exp;
    bit          skip_req;
    bit          pending;
    logic [63:0] pend_addr;
    bit          stalled;
    logic [63:0] stall_addr;
    int          acc_cnt;
    int          pop_cnt;
    int          mem_mode;   // 0: ready, 1: random, 2: stalled
    int          dec_mode;   // 0: ready, 1: random, 2: stalled

    task automatic model_reset();
        exp_pc   = RESET_PC;
        req_exp  = RESET_PC;
        skip_req = 0;
        pending  = 0;
        stalled  = 0;
        acc_cnt  = 0;
        pop_cnt  = 0;
    endtask

    task automatic cycle();
        if (stalled && imem_req_valid) check("req_addr_stable", imem_req_addr, stall_addr);
        stalled    = imem_req_valid && !imem_req_ready;
        stall_addr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            if (skip_req) begin
                skip_req = 0;
            end else begin
                check("req_addr", imem_req_addr, req_exp);
                req_exp += 64'd4;
            end
            pending   = 1;
            pend_addr = imem_req_addr;
            acc_cnt++;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            check("pop_pc", pc_o, exp_pc);
            check("pop_instr", 64'(instr_o), 64'(mem_word(exp_pc)));
            exp_pc += 64'd4;
            pop_cnt++;
        end
        if (redirect_valid) begin
            exp_pc   = redirect_pc & ~64'h3;
            req_exp  = exp_pc;
            skip_req = imem_req_valid && !imem_req_ready;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = pending;
        imem_rsp_data  = pending ? mem_word(pend_addr) : $urandom;
        pending        = 0;
        redirect_valid = 1'b0;
        halt_i         = 1'b0;
        imem_req_ready = (mem_mode == 0) ? 1'b1 : (mem_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        instr_ready    = (dec_mode == 0) ? 1'b1 : (dec_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
        check({tag, "_req_addr"}, imem_req_addr, 64'd0);
        check({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
        check({tag, "_instr"}, 64'(instr_o), 64'd0);
        check({tag, "_pc"}, pc_o, 64'd0);
        check({tag, "_halted"}, 64'(halted_o), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        halt_i         = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int reqs;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_i         = 1'b0;
        instr_ready    = 1'b0;
        mem_mode       = 0;
        dec_mode       = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // first-fetch latency
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check($sformatf("latency_c%0d", i), 64'(instr_valid), 64'(i == 3));
        end
        check("first_pc", pc_o, RESET_PC);
        check("first_instr", 64'(instr_o), 64'h0010_0093);
        repeat (6) cycle();
        check("second_delivered", 64'(pop_cnt >= 2), 64'd1);

        // FIFO fills, fetch stops, one pop frees one slot
        do_reset("rst_fill");
        dec_mode    = 2;
        instr_ready = 1'b0;
        repeat (15) cycle();
        check("full_no_req", 64'(imem_req_valid), 64'd0);
        check("full_buffered", 64'(acc_cnt - pop_cnt), 64'd2);
        instr_ready = 1'b1;
        cycle();
        check("one_pop", 64'(pop_cnt), 64'd1);
        n = 0;
        while (acc_cnt < 3 && n < 20) begin cycle(); n++; end
        check("refill_timeout", 64'(n < 20), 64'd1);
        check("refill_addr", pend_addr, RESET_PC + 64'd8);

        // memory stall holds request
        dec_mode = 0;
        mem_mode = 2;
        n = 0;
        while (!imem_req_valid && n < 30) begin cycle(); n++; end
        check("stall_timeout", 64'(n < 30), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_valid", 64'(imem_req_valid), 64'd1);
        end
        mem_mode       = 0;
        imem_req_ready = 1'b1;
        cycle();
        check("stall_accept_wait", 64'(imem_req_valid), 64'd0);

        // redirect in WAIT with a buffered word
        dec_mode    = 2;
        instr_ready = 1'b0;
        n = 0;
        while (!(instr_valid && imem_rsp_valid) && n < 40) begin cycle(); n++; end
        check("redir_setup_timeout", 64'(n < 40), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        cycle();
        check("redir_flush", 64'(instr_valid), 64'd0);
        dec_mode = 0;
        n = 0;
        while (!instr_valid && n < 20) begin cycle(); n++; end
        check("redir_timeout", 64'(n < 20), 64'd1);
        check("redir_pc", pc_o, 64'h8000_1000);
        check("redir_instr", 64'(instr_o), 64'(mem_word(64'h8000_1000)));

        // randomized traffic with occasional (sometimes misaligned) redirects
        mem_mode = 1;
        dec_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc) | 32'($urandom_range(0, 3))};
            end
            cycle();
        end
        check("random_progress", 64'(pop_cnt > 20), 64'd1);

        // halt with one word buffered
        mem_mode = 0;
        dec_mode = 2;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        n = 0;
        while (!instr_valid && n < 40) begin cycle(); n++; end
        check("halt_setup_timeout", 64'(n < 40), 64'd1);
        halt_i = 1'b1;
        cycle();
        check("halt_valid", 64'(instr_valid), 64'd0);
        check("halt_flag", 64'(halted_o), 64'd1);
        repeat (5) cycle();
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (imem_req_valid) reqs++;
        end
        check("halt_no_req", 64'(reqs), 64'd0);
        check("halt_sticky", 64'(halted_o), 64'd1);

        // reset while in WAIT, then while in REQ
        do_reset("rst_halt");
        n = 0;
        while (!imem_rsp_valid && n < 20) begin cycle(); n++; end
        check("wait_setup_timeout", 64'(n < 20), 64'd1);
        do_reset("rst_wait");
        mem_mode = 2;
        imem_req_ready = 1'b0;
        n = 0;
        while (!imem_req_valid && n < 20) begin cycle(); n++; end
        check("req_setup_timeout", 64'(n < 20), 64'd1);
        do_reset("rst_req");
        mem_mode = 0;
        dec_mode = 0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        n = 0;
        while (!instr_valid && n < 20) begin cycle(); n++; end
        check("restart_timeout", 64'(n < 20), 64'd1);
        check("restart_pc", pc_o, RESET_PC);
        repeat (10) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
